rx_majority_tx_replicator: RTL and testbench
============================================

# rx_majority_tx_replicator

Transmit-side counterpart of the redundant segment receive path. Captures one payload segment from an upstream byte stream into an internal buffer, then emits it as `redundancy` identical Ethernet/IPv4 frames back-to-back on a GMII-style byte stream. Each copy carries the segment number, a copy index and a burst sequence byte, so the receive-side majority voters can line copies up. Sits between the payload source and the GMII TX framer, which adds preamble/SFD and FCS.

## Interface
Parameters:
- `PAYLOAD_LEN`, 1024: payload bytes per frame, 1..4096.
- `IFG_CYCLES`, 12: idle cycles after every frame, ≥1.
- `DST_MAC`, 48'hdeadbeef0123: frame bytes 0-5.
- `SRC_MAC`, 48'h000a35000001: frame bytes 6-11.
- `SRC_IP`, 32'hc0a80140: frame bytes 26-29.
- `DST_IP`, 32'hc0a80102: frame bytes 30-33.
- `IP_CSUM`, 16'h0000: IPv4 header checksum, computed offline for the constant header.

Ports:
- `clk125MHz`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `in_enable`  in  1  high for one contiguous burst per segment.
- `in_data`  in  8  payload byte, valid while `in_enable`.
- `in_segment`  in  16  segment number, sampled on the first `in_enable` cycle.
- `redundancy`  in  8  copies per segment, sampled on the first `in_enable` cycle; 0 is treated as 1.
- `busy`  out  1  high from first load byte until the last gap cycle ends.
- `tx_en`  out  1  frame byte valid.
- `tx_data`  out  8  frame byte; 0x00 whenever `tx_en`=0.
- `frame_done`  out  1  one-cycle pulse on each frame's last byte.
- `drop`  out  1  one-cycle pulse when a burst starts while `busy` is high outside LOAD.

## Operation
- FSM: IDLE → LOAD → HDR → PAY → GAP → (HDR if copies remain, else IDLE).
- IDLE: a rising `in_enable` enters LOAD. That cycle writes `in_data` to buffer address 0, latches `in_segment` and `redundancy`, and increments the 8-bit burst counter `seq`.
- LOAD: each `in_enable`=1 cycle writes the next address.
  - Writes beyond `PAYLOAD_LEN`-1 are discarded.
  - The first `in_enable`=0 cycle enters HDR.
  - Unwritten addresses are sent as 0x00. A per-burst valid-length counter handles this; the buffer is not cleared.
- HDR emits bytes 0-37:
  - 0-5 `DST_MAC`; 6-11 `SRC_MAC`; 12-13 0x08,0x00.
  - 14-25: 0x45, 0x00, total length = 20+4+`PAYLOAD_LEN` (16-bit, MSB first), 0x00,0x00, 0x40,0x00, 0x40, 0x11, `IP_CSUM` MSB first.
  - 26-29 `SRC_IP`; 30-33 `DST_IP`.
  - 34-35 segment number, MSB first; 36 copy index (0-based); 37 `seq`.
- PAY emits buffer bytes 0..`PAYLOAD_LEN`-1.
  - Buffer is a synchronous-read RAM. Its read is prefetched during HDR so there are no bubbles.
  - `frame_done` pulses on the last byte.
- GAP: `tx_en`=0 for exactly `IFG_CYCLES` cycles, then:
  - copy index +1 and back to HDR if index+1 < effective redundancy;
  - otherwise IDLE with `busy` low.
- Bursts arriving in HDR/PAY/GAP are ignored entirely (no buffer write, no latch) and pulse `drop` once on their first cycle.
- `in_enable` must be low for at least one cycle while in IDLE before a new burst is accepted.
- Counters:
  - byte index 13 bits; copy index 8 bits; gap counter ≥ clog2(`IFG_CYCLES`+1) bits.
  - `seq` wraps 255→0.

## Timing
- Reset values: `busy`=0, `tx_en`=0, `tx_data`=0x00, `frame_done`=0, `drop`=0; FSM=IDLE; `seq`=0.
- Reset mid-frame: `tx_en` is low from the next edge, and no `frame_done` pulses. A burst in progress is lost.
- All outputs are registered.
- If `in_enable` is first sampled low at edge T, then `tx_en`=1 with byte 0 from edge T+1.
- Frame length is exactly 38+`PAYLOAD_LEN` consecutive `tx_en` cycles. Copy period is 38+`PAYLOAD_LEN`+`IFG_CYCLES` cycles.
- `busy` rises on the edge after the first `in_enable` sample. It falls on the edge that ends the final gap. A burst may start in that same cycle (IDLE accepts it).

## Test plan
- `PAYLOAD_LEN`=16, `redundancy`=3, segment 0x0005, burst 0x00..0x0F -> three 54-byte frames, each followed by 12 idle cycles. Bytes 34-35 = 00 05; byte 36 = 0,1,2; byte 37 = 0x01; payload matches. 3 `frame_done` pulses.
- `redundancy`=0, 4-byte burst AA BB CC DD with `PAYLOAD_LEN`=16 -> one frame. Payload is AA BB CC DD followed by twelve 0x00. Total length bytes 16-17 = 0x00,0x28.
- 20-byte burst with `PAYLOAD_LEN`=16 -> only the first 16 bytes are transmitted; frame length 54.
- Second burst asserted during copy 1 of 3 -> one `drop` pulse; copies 1-2 unchanged. Next burst after `busy` falls gives `seq`=0x02.
- `reset` high at payload byte 5 of copy 0 -> `tx_en`=0 the next cycle; `busy`=0. A new burst then yields `seq`=0x01.
- 256 consecutive single-copy bursts -> byte 37 of the last frame is 0x00 (wrap).

Source files
------------

// File: rtl/rx_majority_tx_replicator_if.sv
// rx_majority_tx_replicator_if: payload load stream in, replicated frame byte stream out.
interface rx_majority_tx_replicator_if;
  logic in_enable;
  logic [7:0] in_data;
  logic [15:0] in_segment;
  logic [7:0] redundancy;
  logic busy;
  logic tx_en;
  logic [7:0] tx_data;
  logic frame_done;
  logic drop;
  modport master (output in_enable, in_data, in_segment, redundancy, input busy, tx_en, tx_data, frame_done, drop);
  modport slave (input in_enable, in_data, in_segment, redundancy, output busy, tx_en, tx_data, frame_done, drop);
endinterface

// File: rtl/rx_majority_tx_replicator.sv
// rx_majority_tx_replicator: buffers one payload burst and sends it as N identical Ethernet/IPv4 frames.
module rx_majority_tx_replicator #(
  parameter int PAYLOAD_LEN = 1024,
  parameter int IFG_CYCLES = 12,
  parameter logic [47:0] DST_MAC = 48'hdeadbeef0123,
  parameter logic [47:0] SRC_MAC = 48'h000a35000001,
  parameter logic [31:0] SRC_IP = 32'hc0a80140,
  parameter logic [31:0] DST_IP = 32'hc0a80102,
  parameter logic [15:0] IP_CSUM = 16'h0000
) (
  input logic clk125MHz,
  input logic reset,
  rx_majority_tx_replicator_if.slave bus
);
  localparam int AW = PAYLOAD_LEN > 1 ? $clog2(PAYLOAD_LEN) : 1;
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [12:0] PLEN = 13'(PAYLOAD_LEN);
  localparam logic [12:0] LAST = 13'(PAYLOAD_LEN - 1);
  localparam logic [15:0] TOT_LEN = 16'(24 + PAYLOAD_LEN);
  localparam logic [GW-1:0] GAP_END = GW'(IFG_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, GAP} state_t;
  state_t state;
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd_data, seq, red, copy, hdr_byte;
  logic [15:0] seg;
  logic [12:0] idx, wlen;
  logic [GW-1:0] gap;
  logic en_q, rise, we;
  logic [AW-1:0] waddr, raddr;
  logic [303:0] hdr;
  always_comb begin
    rise = bus.in_enable & ~en_q;
    we = (state == IDLE && rise) || (state == LOAD && bus.in_enable && wlen < PLEN);
    waddr = state == IDLE ? '0 : AW'(wlen);
    raddr = state == PAY ? AW'(idx + 13'd1) : '0;
    hdr = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, TOT_LEN, 16'h0000, 16'h4000, 16'h4011,
           IP_CSUM, SRC_IP, DST_IP, seg, copy, seq};
    hdr_byte = hdr[{6'd37 - idx[5:0], 3'b000} +: 8];
  end
  // Address 0 is read while in HDR so payload byte 0 is ready on the first PAY edge.
  always_ff @(posedge clk125MHz) begin
    if (we) mem[waddr] <= bus.in_data;
    rd_data <= mem[raddr];
  end
  always_ff @(posedge clk125MHz) begin
    en_q <= bus.in_enable;
    if (reset) begin
      state <= IDLE;
      seq <= '0;
      seg <= '0;
      red <= 8'd1;
      copy <= '0;
      idx <= '0;
      wlen <= '0;
      gap <= '0;
      bus.busy <= 1'b0;
      bus.tx_en <= 1'b0;
      bus.tx_data <= '0;
      bus.frame_done <= 1'b0;
      bus.drop <= 1'b0;
    end else begin
      bus.tx_en <= 1'b0;
      bus.tx_data <= '0;
      bus.frame_done <= 1'b0;
      bus.drop <= rise && (state == HDR || state == PAY || state == GAP);
      case (state)
        IDLE: if (rise) begin
          state <= LOAD;
          seg <= bus.in_segment;
          red <= bus.redundancy == 8'd0 ? 8'd1 : bus.redundancy;
          seq <= seq + 8'd1;
          wlen <= 13'd1;
          copy <= '0;
          bus.busy <= 1'b1;
        end
        LOAD: if (bus.in_enable) wlen <= wlen < PLEN ? wlen + 13'd1 : wlen;
        else begin
          state <= HDR;
          idx <= '0;
        end
        HDR: begin
          bus.tx_en <= 1'b1;
          bus.tx_data <= hdr_byte;
          idx <= idx == 13'd37 ? '0 : idx + 13'd1;
          if (idx == 13'd37) state <= PAY;
        end
        // Bytes past the burst's valid length go out as zero; the buffer keeps stale data.
        PAY: begin
          bus.tx_en <= 1'b1;
          bus.tx_data <= idx < wlen ? rd_data : 8'h00;
          idx <= idx + 13'd1;
          if (idx == LAST) begin
            bus.frame_done <= 1'b1;
            state <= GAP;
            gap <= '0;
          end
        end
        GAP: begin
          gap <= gap + GW'(1);
          if (gap == GAP_END) begin
            if ({1'b0, copy} + 9'd1 < {1'b0, red}) begin
              copy <= copy + 8'd1;
              idx <= '0;
              state <= HDR;
            end else begin
              state <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_majority_tx_replicator.sv
// tb_rx_majority_tx_replicator: randomized bursts checked against a frame-building reference model.
module tb_rx_majority_tx_replicator;
  localparam int PL = 16;
  localparam int IFG = 12;
  localparam int FL = 38 + PL;
  typedef logic [7:0] bq_t[$];
  logic clk125MHz = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int drops = 0;
  logic [7:0] mseq = 8'd0;
  always #4 clk125MHz = ~clk125MHz;
  rx_majority_tx_replicator_if bus();
  rx_majority_tx_replicator #(.PAYLOAD_LEN(PL), .IFG_CYCLES(IFG)) dut (
    .clk125MHz(clk125MHz),
    .reset(reset),
    .bus(bus)
  );
  always @(negedge clk125MHz) if (bus.drop === 1'b1) drops++;

  function automatic bq_t build_frame(logic [15:0] seg, logic [7:0] cp, logic [7:0] sq, bq_t pay);
    bq_t f;
    logic [47:0] dm = 48'hdeadbeef0123;
    logic [47:0] sm = 48'h000a35000001;
    logic [31:0] si = 32'hc0a80140;
    logic [31:0] di = 32'hc0a80102;
    logic [15:0] tl = 16'(20 + 4 + PL);
    f = {};
    for (int i = 5; i >= 0; i--) f.push_back(dm[8*i +: 8]);
    for (int i = 5; i >= 0; i--) f.push_back(sm[8*i +: 8]);
    f = {f, 8'h08, 8'h00, 8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00};
    for (int i = 3; i >= 0; i--) f.push_back(si[8*i +: 8]);
    for (int i = 3; i >= 0; i--) f.push_back(di[8*i +: 8]);
    f = {f, seg[15:8], seg[7:0], cp, sq};
    for (int i = 0; i < PL; i++) f.push_back(i < pay.size() ? pay[i] : 8'h00);
    return f;
  endfunction

  function automatic int first_diff(bq_t a, bq_t b);
    int n = a.size() < b.size() ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    return a.size() != b.size() ? n : -1;
  endfunction

  function automatic string diff_str(bq_t a, bq_t b, int d);
    return $sformatf("byte %0d got %h required %h, length got %0d required %0d", d,
      d < a.size() ? a[d] : 8'hxx, d < b.size() ? b[d] : 8'hxx, a.size(), b.size());
  endfunction

  function automatic bq_t rand_bytes(int n);
    bq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    bus.in_enable = 1'b0;
    bus.in_data = '0;
    bus.in_segment = '0;
    bus.redundancy = '0;
    repeat (3) @(negedge clk125MHz);
    reset = 1'b0;
    mseq = 8'd0;
  endtask

  task automatic send_burst(input logic [15:0] seg, input logic [7:0] red, input bq_t d, input bit accept);
    for (int i = 0; i < d.size(); i++) begin
      @(negedge clk125MHz);
      bus.in_enable = 1'b1;
      bus.in_data = d[i];
      bus.in_segment = i == 0 ? seg : 16'($urandom);
      bus.redundancy = i == 0 ? red : 8'($urandom);
    end
    @(negedge clk125MHz);
    bus.in_enable = 1'b0;
    bus.in_data = 8'($urandom);
    if (accept) mseq = mseq + 8'd1;
  endtask

  task automatic capture(output bq_t f, output int lead, output int fd_bad, output bit to);
    int fdc;
    logic last_fd;
    f = {};
    lead = 0;
    fdc = 0;
    last_fd = 1'b0;
    do begin
      @(negedge clk125MHz);
      lead++;
    end while (bus.tx_en !== 1'b1 && lead < 3000);
    to = bus.tx_en !== 1'b1;
    while (bus.tx_en === 1'b1 && f.size() < 5000) begin
      f.push_back(bus.tx_data);
      last_fd = bus.frame_done;
      fdc += int'(bus.frame_done === 1'b1);
      @(negedge clk125MHz);
    end
    fd_bad = fdc - int'(last_fd === 1'b1) + int'(last_fd !== 1'b1);
  endtask

  task automatic wait_idle(output int n);
    n = 1;
    while (bus.busy === 1'b1 && n < 500) begin
      @(negedge clk125MHz);
      n++;
    end
  endtask

  task automatic test_reset;
    do_reset();
    tests++;
    if ({bus.busy, bus.tx_en, bus.tx_data, bus.frame_done, bus.drop} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 000000000000", {bus.busy, bus.tx_en, bus.tx_data, bus.frame_done, bus.drop});
    end
  endtask

  task automatic test_basic;
    bq_t pay, f, e;
    int lead, fdb, d, n;
    bit to;
    do_reset();
    pay = {};
    for (int i = 0; i < 16; i++) pay.push_back(8'(i));
    send_burst(16'h0005, 8'd3, pay, 1'b1);
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_busy_rise: got %b required 1", bus.busy); end
    for (int c = 0; c < 3; c++) begin
      capture(f, lead, fdb, to);
      e = build_frame(16'h0005, 8'(c), mseq, pay);
      d = first_diff(f, e);
      tests++;
      if (to) begin fails++; $display("FAIL basic_timeout copy %0d: got no frame required frame", c); end
      tests++;
      if (lead != (c == 0 ? 2 : IFG)) begin fails++; $display("FAIL basic_lead copy %0d: got %0d required %0d", c, lead, c == 0 ? 2 : IFG); end
      tests++;
      if (d != -1) begin fails++; $display("FAIL basic_frame copy %0d: %s", c, diff_str(f, e, d)); end
      tests++;
      if (fdb != 0) begin fails++; $display("FAIL basic_frame_done copy %0d: got %0d misplaced pulses required 0", c, fdb); end
    end
    wait_idle(n);
    tests++;
    if (n != IFG) begin fails++; $display("FAIL basic_busy_fall: got %0d cycles required %0d", n, IFG); end
  endtask

  task automatic test_zero_redundancy;
    bq_t pay, f, e;
    int lead, fdb, d, extra;
    bit to;
    logic [15:0] seg;
    do_reset();
    pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    seg = 16'($urandom);
    send_burst(seg, 8'd0, pay, 1'b1);
    capture(f, lead, fdb, to);
    e = build_frame(seg, 8'd0, mseq, pay);
    d = first_diff(f, e);
    tests++;
    if (d != -1) begin fails++; $display("FAIL zero_red_frame: %s", diff_str(f, e, d)); end
    tests++;
    if (f.size() < 18 || {f[16], f[17]} !== 16'h0028) begin
      fails++;
      $display("FAIL zero_red_total_len: got %h required 0028", f.size() < 18 ? 16'hxxxx : {f[16], f[17]});
    end
    extra = 0;
    repeat (2 * (FL + IFG)) begin
      @(negedge clk125MHz);
      extra += int'(bus.tx_en === 1'b1);
    end
    tests++;
    if (extra != 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_red_single_copy: got %0d extra bytes busy %b required 0 and 0", extra, bus.busy);
    end
  endtask

  task automatic test_overlong;
    bq_t pay, f, e;
    int lead, fdb, d, n;
    bit to;
    logic [15:0] seg;
    do_reset();
    pay = rand_bytes(20);
    seg = 16'($urandom);
    send_burst(seg, 8'd1, pay, 1'b1);
    capture(f, lead, fdb, to);
    e = build_frame(seg, 8'd0, mseq, pay);
    d = first_diff(f, e);
    tests++;
    if (d != -1) begin fails++; $display("FAIL overlong_frame: %s", diff_str(f, e, d)); end
    tests++;
    if (f.size() != FL) begin fails++; $display("FAIL overlong_len: got %0d required %0d", f.size(), FL); end
    wait_idle(n);
  endtask

  task automatic test_drop;
    bq_t pay, f, e;
    int lead, fdb, d, n, d0;
    bit to;
    logic [15:0] seg;
    do_reset();
    pay = rand_bytes(PL);
    seg = 16'($urandom);
    send_burst(seg, 8'd3, pay, 1'b1);
    capture(f, lead, fdb, to);
    d0 = drops;
    fork
      capture(f, lead, fdb, to);
      begin
        repeat (20) @(negedge clk125MHz);
        send_burst(16'($urandom), 8'd5, rand_bytes(6), 1'b0);
      end
    join
    for (int c = 1; c < 3; c++) begin
      if (c == 2) capture(f, lead, fdb, to);
      e = build_frame(seg, 8'(c), mseq, pay);
      d = first_diff(f, e);
      tests++;
      if (d != -1) begin fails++; $display("FAIL drop_copy%0d_frame: %s", c, diff_str(f, e, d)); end
    end
    tests++;
    if (drops - d0 != 1) begin fails++; $display("FAIL drop_pulse: got %0d cycles required 1", drops - d0); end
    wait_idle(n);
    pay = rand_bytes(PL);
    send_burst(seg, 8'd1, pay, 1'b1);
    capture(f, lead, fdb, to);
    tests++;
    if (f.size() < 38 || f[37] !== 8'h02) begin fails++; $display("FAIL drop_next_seq: got %h required 02", f.size() < 38 ? 8'hxx : f[37]); end
    wait_idle(n);
  endtask

  task automatic test_reset_mid_frame;
    bq_t pay, f, e;
    int lead, fdb, d, n, bad;
    bit to;
    logic [15:0] seg;
    do_reset();
    pay = rand_bytes(PL);
    seg = 16'($urandom);
    send_burst(seg, 8'd1, pay, 1'b1);
    n = 0;
    d = 0;
    while (n < 44 && d < 500) begin
      @(negedge clk125MHz);
      d++;
      n += int'(bus.tx_en === 1'b1);
    end
    tests++;
    if (n != 44) begin fails++; $display("FAIL reset_mid_reach: got %0d bytes required 44", n); end
    reset = 1'b1;
    @(negedge clk125MHz);
    tests++;
    if ({bus.tx_en, bus.busy} !== 2'b00) begin fails++; $display("FAIL reset_mid_outputs: got tx_en/busy %b required 00", {bus.tx_en, bus.busy}); end
    reset = 1'b0;
    mseq = 8'd0;
    bad = 0;
    repeat (FL + IFG + 10) begin
      @(negedge clk125MHz);
      bad += int'(bus.tx_en === 1'b1 || bus.frame_done === 1'b1);
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset_mid_quiet: got %0d active cycles required 0", bad); end
    pay = rand_bytes(PL);
    send_burst(seg, 8'd1, pay, 1'b1);
    capture(f, lead, fdb, to);
    e = build_frame(seg, 8'd0, mseq, pay);
    d = first_diff(f, e);
    tests++;
    if (d != -1 || f[37] !== 8'h01) begin fails++; $display("FAIL reset_mid_next_frame: %s", diff_str(f, e, d < 0 ? 37 : d)); end
    wait_idle(n);
  endtask

  task automatic test_random;
    bq_t pay, f, e;
    int lead, fdb, d, n, copies;
    bit to;
    logic [15:0] seg;
    logic [7:0] red;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      pay = rand_bytes($urandom_range(1, 24));
      seg = 16'($urandom);
      red = 8'($urandom_range(0, 4));
      copies = red == 0 ? 1 : int'(red);
      send_burst(seg, red, pay, 1'b1);
      for (int c = 0; c < copies; c++) begin
        capture(f, lead, fdb, to);
        e = build_frame(seg, 8'(c), mseq, pay);
        d = first_diff(f, e);
        tests++;
        if (d != -1 || fdb != 0) begin fails++; $display("FAIL random_b%0d_c%0d: %s, frame_done errors %0d", b, c, diff_str(f, e, d), fdb); end
      end
      wait_idle(n);
      tests++;
      if (bus.busy !== 1'b0) begin fails++; $display("FAIL random_b%0d_idle: got busy %b required 0", b, bus.busy); end
    end
  endtask

  task automatic test_seq_wrap;
    bq_t pay, f, e;
    int lead, fdb, d, n, bad;
    bit to;
    logic [15:0] seg;
    do_reset();
    bad = 0;
    for (int b = 0; b < 256; b++) begin
      pay = rand_bytes($urandom_range(1, 20));
      seg = 16'($urandom);
      send_burst(seg, 8'($urandom_range(0, 1)), pay, 1'b1);
      capture(f, lead, fdb, to);
      e = build_frame(seg, 8'd0, mseq, pay);
      d = first_diff(f, e);
      if (d != -1 && bad < 3) $display("FAIL seq_wrap_burst%0d: %s", b, diff_str(f, e, d));
      bad += int'(d != -1);
      wait_idle(n);
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL seq_wrap_frames: got %0d bad frames required 0", bad); end
    tests++;
    if (f.size() < 38 || f[37] !== 8'h00) begin fails++; $display("FAIL seq_wrap_last: got %h required 00", f.size() < 38 ? 8'hxx : f[37]); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_redundancy();
    test_overlong();
    test_drop();
    test_reset_mid_frame();
    test_random();
    test_seq_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
